// File: rtl/bcd_strobe_arbiter_if.sv
// Request/grant bundle between ten active-low requesters and the BCD strobe arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface bcd_strobe_arbiter_if;
    logic [9:0] req_n;
    logic       done_n;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic [9:0] y_n;
    logic       gnt_valid;
    logic       tmo;

    modport master (
        output req_n, done_n,
        input  a, b, c, d, y_n, gnt_valid, tmo
    );

    modport slave (
        input  req_n, done_n,
        output a, b, c, d, y_n, gnt_valid, tmo
    );
endinterface

// File: rtl/bcd_strobe_arbiter.sv
// Round-robin arbiter for ten active-low requesters, grant driven as a BCD code plus decode.
// Optional forced release on grant age is enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_strobe_arbiter #(
    parameter int unsigned MIN_HOLD = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    bcd_strobe_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StGrant, StHold, StGap} state_e;

    state_e     state_q;
    logic [3:0] ptr_q;
    logic [3:0] code_q;
    logic [3:0] cnt_q;
    logic [9:0] y_q;
    logic       gnt_q;

    logic       found;
    logic [3:0] winner;
    logic [3:0] cand;
    logic       release_req;

    function automatic logic [9:0] decode(input logic [3:0] code);
        decode = 10'h3FF;
        if (code < 4'd10) decode[code] = 1'b0;
    endfunction

    // First low request searching upward from the slot after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            cand = 4'((int'(ptr_q) + i) % 10);
            if (!found && !bus.req_n[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // ptr_q always names the current holder while a grant is live.
    assign release_req = !bus.done_n || bus.req_n[ptr_q];

`ifdef BCD_ARB_TIMEOUT_EN
    logic [7:0] age_q;
    logic       tmo_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 4'd9;
            code_q  <= 4'hF;
            y_q     <= 10'h3FF;
            gnt_q   <= 1'b0;
            cnt_q   <= 4'd0;
`ifdef BCD_ARB_TIMEOUT_EN
            age_q   <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
`ifdef BCD_ARB_TIMEOUT_EN
            tmo_q <= 1'b0;
            if (state_q == StGrant || state_q == StHold) age_q <= age_q + 8'd1;
`endif
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q <= StGrant;
                        ptr_q   <= winner;
                        code_q  <= winner;
                        y_q     <= decode(winner);
                        gnt_q   <= 1'b1;
                        cnt_q   <= 4'd0;
`ifdef BCD_ARB_TIMEOUT_EN
                        age_q   <= 8'd0;
`endif
                    end
                end
                StGrant: begin
                    if (cnt_q == 4'(MIN_HOLD - 1)) state_q <= StHold;
                    else cnt_q <= cnt_q + 4'd1;
                end
                StHold: begin
`ifdef BCD_ARB_TIMEOUT_EN
                    if (release_req || age_q == 8'(TIMEOUT - 1)) begin
                        tmo_q <= !release_req;
`else
                    if (release_req) begin
`endif
                        state_q <= StGap;
                        code_q  <= 4'hF;
                        y_q     <= 10'h3FF;
                        gnt_q   <= 1'b0;
                        cnt_q   <= 4'd0;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.a         = code_q[0];
    assign bus.b         = code_q[1];
    assign bus.c         = code_q[2];
    assign bus.d         = code_q[3];
    assign bus.y_n       = y_q;
    assign bus.gnt_valid = gnt_q;
`ifdef BCD_ARB_TIMEOUT_EN
    assign bus.tmo       = tmo_q;
`else
    assign bus.tmo       = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_strobe_arbiter.sv
// Scoreboard bench for bcd_strobe_arbiter: a grant-level reference model predicts every cycle,
// a monitor compares the DUT outputs against the queued predictions.
module tb_bcd_strobe_arbiter;
    localparam int unsigned TB_MIN_HOLD = 4;
    localparam int unsigned TB_TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_strobe_arbiter_if bus ();

    bcd_strobe_arbiter #(
        .MIN_HOLD(TB_MIN_HOLD),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [3:0] code;
        logic       gnt;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: who holds the grant, for how many cycles, and whether a gap cycle is due.
    int   m_holder = -1;
    int   m_age    = 0;
    int   m_last   = 9;
    bit   m_gap    = 1'b0;

    function automatic logic [9:0] ref_y(input logic [3:0] code);
        ref_y = 10'h3FF;
        if (code < 4'd10) ref_y = ~(10'd1 << code);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [9:0] q, input logic dn);
        exp_t e;
        bit   t = 1'b0;
        if (!r) begin
            m_holder = -1;
            m_gap    = 1'b0;
            m_last   = 9;
            m_age    = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_holder < 0) begin
            for (int i = 1; i <= 10; i++) begin
                int c = (m_last + i) % 10;
                if (!q[c[3:0]]) begin
                    m_holder = c;
                    m_last   = c;
                    m_age    = 1;
                    break;
                end
            end
        end else if (m_age > int'(TB_MIN_HOLD) && (!dn || q[m_holder[3:0]])) begin
            m_holder = -1;
            m_gap    = 1'b1;
        end
`ifdef BCD_ARB_TIMEOUT_EN
        else if (m_age > int'(TB_MIN_HOLD) && m_age == int'(TB_TIMEOUT)) begin
            m_holder = -1;
            m_gap    = 1'b1;
            t        = 1'b1;
        end
`endif
        else begin
            m_age++;
        end
        e.code = (m_holder >= 0) ? 4'(m_holder) : 4'hF;
        e.gnt  = (m_holder >= 0);
        e.tmo  = t;
        sb.push_back(e);
    endtask

    // Inputs change 2 time units after a rising edge and are sampled at the next one.
    task automatic drive(input logic r, input logic [9:0] q, input logic dn);
        @(posedge clk);
        #2;
        rst_n      = r;
        bus.req_n  = q;
        bus.done_n = dn;
        model_step(r, q, dn);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("code", 32'({bus.d, bus.c, bus.b, bus.a}), 32'(mon_e.code));
                chk("y_n", 32'(bus.y_n), 32'(ref_y(mon_e.code)));
                chk("gnt_valid", 32'(bus.gnt_valid), 32'(mon_e.gnt));
                chk("tmo", 32'(bus.tmo), 32'(mon_e.tmo));
                chk("y_onehot", 32'($countones(~bus.y_n) <= 1), 32'd1);
            end
        end
    end

    initial begin
        logic [9:0] q;
        int         dens;
        rst_n      = 1'b0;
        bus.req_n  = 10'h3FF;
        bus.done_n = 1'b1;
        repeat (3) drive(1'b0, 10'h3FF, 1'b1);

        // Requester 2 alone, released by done after eight cycles.
        for (int k = 0; k < 14; k++) drive(1'b1, 10'h3FB, (k >= 8) ? 1'b0 : 1'b1);
        repeat (3) drive(1'b1, 10'h3FF, 1'b1);

        // Done low from the start: grant lasts only the minimum dwell plus one hold cycle.
        repeat (10) drive(1'b1, 10'h37F, 1'b0);
        repeat (3) drive(1'b1, 10'h3FF, 1'b1);

        // All ten requesting: full rotation with wrap back to 0.
        repeat (2) drive(1'b0, 10'h3FF, 1'b1);
        repeat (85) drive(1'b1, 10'h000, 1'b0);

        // Reset during the hold of requester 5, then everyone requests.
        repeat (2) drive(1'b0, 10'h3FF, 1'b1);
        repeat (8) drive(1'b1, 10'h3DF, 1'b1);
        drive(1'b0, 10'h3DF, 1'b1);
        repeat (12) drive(1'b1, 10'h000, 1'b1);

        // Requester 3 never releases: held forever, or forced off by the age limit.
        repeat (2) drive(1'b0, 10'h3FF, 1'b1);
        repeat (60) drive(1'b1, 10'h3F7, 1'b1);
        repeat (40) drive(1'b1, 10'h3E7, 1'b1);

        // Randomized phases of varying request density with sparse resets.
        dens = 30;
        for (int k = 0; k < 1500; k++) begin
            if (k % 100 == 0) dens = int'($urandom_range(5, 60));
            for (int b = 0; b < 10; b++) q[b] = ($urandom_range(99) >= 32'(dens));
            drive(($urandom_range(199) != 0), q, ($urandom_range(99) >= 30));
        end

        repeat (3) drive(1'b1, 10'h3FF, 1'b1);
        @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
